// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV64 fetch stage: PC register, imem req/ready handshake, IR latch
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC       = 64'h0000_0000_0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        pc_write,
  input  logic [63:0] pc_next,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction,
  output logic        ir_valid,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic [63:0] fetched_pc,
  output logic        busy,
  output logic        fault
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [31:0] TO_LIMIT = TIMEOUT_CYCLES[31:0];
  localparam logic [31:0] NOP      = 32'h0000_0013;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_pc;
  logic [63:0] r_imem_addr;
  logic        r_imem_req;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic [63:0] r_fetched_pc;
  logic        r_fault;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_inc;
  logic        w_timeout;
  logic        w_start;
  logic        w_accept;

  assign w_cnt_inc = r_cnt + 32'd1;
  // Counter value after this REQ cycle reaching the limit ends the request.
  assign w_timeout = (TO_LIMIT != 32'd0) && (w_cnt_inc == TO_LIMIT);
  assign w_start   = (r_state == S_IDLE) && fetch_en;
  assign w_accept  = (r_state == S_REQ) && imem_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (fetch_en) w_state_next = S_REQ;
      S_REQ:  if (imem_ready || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_imem_addr  <= RESET_PC;
      r_imem_req   <= 1'b0;
      r_ir         <= NOP;
      r_ir_valid   <= 1'b0;
      r_fetched_pc <= RESET_PC;
      r_fault      <= 1'b0;
      r_cnt        <= 32'd0;
    end else begin
      if (w_start) begin
        r_imem_addr <= r_pc;
        r_imem_req  <= 1'b1;
        r_ir_valid  <= 1'b0;
        r_cnt       <= 32'd0;
      end
      if (r_state == S_REQ) begin
        if (imem_ready) begin
          r_ir         <= imem_rdata;
          r_fetched_pc <= r_imem_addr;
          r_ir_valid   <= 1'b1;
          r_imem_req   <= 1'b0;
        end else begin
          r_cnt <= w_cnt_inc;
          if (w_timeout) begin
            r_imem_req <= 1'b0;
            r_fault    <= 1'b1;
          end
        end
      end
      // PC updates are only legal between fetches and must stay word aligned.
      if (pc_write) begin
        if ((r_state == S_IDLE) && (pc_next[1:0] == 2'b00)) r_pc <= pc_next;
        else r_fault <= 1'b1;
      end
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instruction = r_ir;
  assign ir_valid    = r_ir_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 64'd4;
  assign fetched_pc  = r_fetched_pc;
  assign busy        = (r_state == S_REQ);
  assign fault       = r_fault;

  logic w_unused;
  assign w_unused = w_accept;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, pc_write, imem_ready;
  logic [63:0] pc_next;
  logic [31:0] imem_rdata;
  logic        imem_req, ir_valid, busy, fault;
  logic [63:0] imem_addr, pc, pc_plus4, fetched_pc;
  logic [31:0] instruction;

  logic        fetch_en2;
  logic        imem_req2, ir_valid2, busy2, fault2;
  logic [63:0] imem_addr2, pc2, pc_plus4_2, fetched_pc2;
  logic [31:0] instruction2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT_CYCLES(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_write(pc_write),
    .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instruction(instruction),
    .ir_valid(ir_valid), .pc(pc), .pc_plus4(pc_plus4), .fetched_pc(fetched_pc),
    .busy(busy), .fault(fault)
  );

  instr_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en2), .pc_write(1'b0),
    .pc_next(64'h0), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(32'hFFFF_FFFF), .imem_ready(1'b0), .instruction(instruction2),
    .ir_valid(ir_valid2), .pc(pc2), .pc_plus4(pc_plus4_2), .fetched_pc(fetched_pc2),
    .busy(busy2), .fault(fault2)
  );

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; pc_write = 1'b0; pc_next = 64'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0; fetch_en2 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    check_vec("rst_pc", pc, 64'h0);
    check_vec("rst_addr", imem_addr, 64'h0);
    check_vec("rst_fpc", fetched_pc, 64'h0);
    check_vec("rst_ir", {32'h0, instruction}, 64'h13);
    check_vec("rst_flags", {60'h0, ir_valid, imem_req, busy, fault}, 64'h0);

    // single fetch, ready on first REQ cycle
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check_vec("f1_req", {63'h0, imem_req}, 64'h1);
    check_vec("f1_addr", imem_addr, 64'h0);
    check_vec("f1_irv0", {63'h0, ir_valid}, 64'h0);
    imem_ready = 1'b1; imem_rdata = 32'h00A0_0093;
    tick();
    imem_ready = 1'b0;
    check_vec("f1_ir", {32'h0, instruction}, 64'h00A0_0093);
    check_vec("f1_fpc", fetched_pc, 64'h0);
    check_vec("f1_irv", {63'h0, ir_valid}, 64'h1);
    check_vec("f1_req_lo", {63'h0, imem_req}, 64'h0);
    tick();
    check_vec("f1_req_lo2", {63'h0, imem_req}, 64'h0);

    // fetch at PC while writing PC+4, then fetch again
    check_vec("f2_pp4", pc_plus4, 64'h4);
    fetch_en = 1'b1; pc_write = 1'b1; pc_next = 64'h4;
    tick();
    fetch_en = 1'b0; pc_write = 1'b0;
    check_vec("f2_addr", imem_addr, 64'h0);
    check_vec("f2_pc", pc, 64'h4);
    check_vec("f2_irv0", {63'h0, ir_valid}, 64'h0);
    imem_ready = 1'b1; imem_rdata = 32'h0010_0113;
    tick();
    imem_ready = 1'b0;
    check_vec("f2_fpc", fetched_pc, 64'h0);
    check_vec("f2_ir", {32'h0, instruction}, 64'h0010_0113);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check_vec("f3_addr", imem_addr, 64'h4);
    imem_ready = 1'b1; imem_rdata = 32'h0020_0193;
    tick();
    imem_ready = 1'b0;
    check_vec("f3_fpc", fetched_pc, 64'h4);
    check_vec("f3_ir", {32'h0, instruction}, 64'h0020_0193);

    // ready delayed 5 cycles: busy for 6 cycles
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_vec("wt_busy", {63'h0, busy}, 64'h1);
      check_vec("wt_addr", imem_addr, 64'h4);
      check_vec("wt_irv", {63'h0, ir_valid}, 64'h0);
      check_vec("wt_ir", {32'h0, instruction}, 64'h0020_0193);
      tick();
    end
    check_vec("wt_busy6", {63'h0, busy}, 64'h1);
    imem_ready = 1'b1; imem_rdata = 32'h0030_0213;
    tick();
    imem_ready = 1'b0;
    check_vec("wt_busy_lo", {63'h0, busy}, 64'h0);
    check_vec("wt_ir_new", {32'h0, instruction}, 64'h0030_0213);
    check_vec("wt_irv1", {63'h0, ir_valid}, 64'h1);
    check_vec("wt_fault", {63'h0, fault}, 64'h0);

    // timeout after 4 REQ cycles on the second instance
    fetch_en2 = 1'b1;
    tick();
    fetch_en2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_vec("to_req", {63'h0, imem_req2}, 64'h1);
      check_vec("to_fault0", {63'h0, fault2}, 64'h0);
      tick();
    end
    check_vec("to_req_lo", {63'h0, imem_req2}, 64'h0);
    check_vec("to_fault", {63'h0, fault2}, 64'h1);
    check_vec("to_ir", {32'h0, instruction2}, 64'h13);
    check_vec("to_irv", {63'h0, ir_valid2}, 64'h0);
    check_vec("to_busy", {63'h0, busy2}, 64'h0);

    // misaligned PC write, then PC write during REQ
    pc_write = 1'b1; pc_next = 64'h1002;
    tick();
    pc_write = 1'b0;
    check_vec("mis_pc", pc, 64'h4);
    check_vec("mis_fault", {63'h0, fault}, 64'h1);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; pc_write = 1'b1; pc_next = 64'h8;
    tick();
    pc_write = 1'b0;
    check_vec("req_pcw_pc", pc, 64'h4);
    check_vec("req_pcw_fault", {63'h0, fault}, 64'h1);
    imem_ready = 1'b1; imem_rdata = 32'h0040_0293;
    tick();
    imem_ready = 1'b0;
    tick();
    check_vec("fault_sticky", {63'h0, fault}, 64'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_vec("fault_clr", {63'h0, fault}, 64'h0);
    check_vec("fault_clr2", {63'h0, fault2}, 64'h0);

    // PC wrap, then reset during REQ
    pc_write = 1'b1; pc_next = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    pc_write = 1'b0;
    check_vec("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_vec("wrap_pp4", pc_plus4, 64'h0);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check_vec("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check_vec("wrap_req", {63'h0, imem_req}, 64'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_vec("mrst_req", {63'h0, imem_req}, 64'h0);
    check_vec("mrst_pc", pc, 64'h0);
    check_vec("mrst_busy", {63'h0, busy}, 64'h0);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    check_vec("late_ir", {32'h0, instruction}, 64'h13);
    check_vec("late_irv", {63'h0, ir_valid}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the multicycle RV64 datapath. Holds the program counter, issues one request per fetch to instruction memory over a req/ready handshake, and latches the returned word into the instruction register (IR). The IR drives the immediate generator, register-file address decode and control unit directly. The block also exposes the PC of the held instruction for branch and jump target arithmetic.

## Interface
- RESET_PC, 64'h0000_0000_0000_0000: PC value loaded on reset.
- TIMEOUT_CYCLES, 255: maximum number of REQ cycles without imem_ready before the fetch is abandoned; 0 disables the timeout.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- fetch_en  in  1  control unit requests a fetch at the current PC.
- pc_write  in  1  load pc_next into PC.
- pc_next  in  64  new PC value (PC+4, branch target or jump target).
- imem_req  out  1  request to instruction memory; registered.
- imem_addr  out  64  fetch address; registered; stable while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory response strobe; sampled only in REQ.
- instruction  out  32  IR contents; feeds the immediate generator.
- ir_valid  out  1  IR holds a word fetched by the most recent fetch.
- pc  out  64  current PC register.
- pc_plus4  out  64  combinational pc + 4, modulo 2^64.
- fetched_pc  out  64  address that the IR contents were fetched from.
- busy  out  1  high in REQ.
- fault  out  1  sticky error flag; cleared only by reset.

## Operation
- Two states: IDLE and REQ.
- IDLE with fetch_en=1:
  - At the edge, imem_addr <= pc (pre-update value), imem_req <= 1, ir_valid <= 0, timeout counter <= 0.
  - Next state is REQ.
- REQ with imem_ready=1:
  - At the edge, instruction <= imem_rdata, fetched_pc <= imem_addr, ir_valid <= 1, imem_req <= 0.
  - Next state is IDLE.
- REQ with imem_ready=0:
  - Counter increments.
  - When the counter reaches TIMEOUT_CYCLES (if nonzero): imem_req <= 0, fault <= 1, IR and fetched_pc unchanged, ir_valid stays 0, next state is IDLE.
- fetch_en in REQ is ignored. No request is queued.
- pc_write in IDLE:
  - If pc_next[1:0]==2'b00: pc <= pc_next.
  - Otherwise pc is unchanged and fault <= 1 (misaligned target).
- pc_write in REQ: dropped (pc unchanged) and fault <= 1.
- fetch_en and pc_write in the same IDLE cycle: the fetch uses the old PC and pc takes pc_next. This is the standard IF-cycle "fetch at PC, write PC+4" case.
- The IR never changes except on an accepted response. It is held stable across decode, execute and writeback cycles.
- pc_plus4 wraps: pc=64'hFFFF_FFFF_FFFF_FFFC gives 64'h0.

## Timing
- Reset values:
  - pc=RESET_PC, imem_addr=RESET_PC, fetched_pc=RESET_PC.
  - instruction=32'h0000_0013 (NOP).
  - ir_valid=0, imem_req=0, busy=0, fault=0, state IDLE, counter 0.
- Handshake:
  - imem_req rises the cycle after fetch_en is sampled in IDLE.
  - The transfer completes on the first edge with imem_req=1 and imem_ready=1.
  - imem_req falls at that same edge.
- Minimum latency is 2 edges from fetch_en to ir_valid=1 (ready asserted in the first REQ cycle). Each wait cycle adds 1.
- Timeout: imem_req drops at the edge where the counter reaches TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES REQ cycles without ready.
- ir_valid stays 1 until the next accepted fetch_en, and clears at the same edge that raises imem_req.
- Reset mid-REQ: at the reset edge imem_req=0 and all outputs take their reset values. A late imem_ready after reset is ignored because the block is in IDLE.

## Test plan
- Reset then fetch_en for 1 cycle, imem_ready=1 on the first REQ cycle with rdata=32'h00A00093:
  - imem_addr=0 and imem_req high for exactly 1 cycle.
  - instruction=32'h00A00093, fetched_pc=0, ir_valid=1 two edges after fetch_en.
- fetch_en and pc_write with pc_next=pc_plus4=4 in the same cycle, then a second fetch:
  - First fetch address 0, second fetch address 4.
  - fetched_pc tracks each fetch.
- imem_ready delayed 5 cycles with TIMEOUT_CYCLES=255:
  - busy high for 6 cycles, imem_addr stable throughout.
  - IR unchanged and ir_valid=0 until the response.
  - fault stays 0.
- TIMEOUT_CYCLES=4, ready never asserted:
  - imem_req drops after 4 REQ cycles and fault=1.
  - instruction keeps its previous value; ir_valid=0.
- pc_write with pc_next=64'h1002:
  - pc unchanged and fault=1.
  - pc_write in REQ: pc unchanged and fault=1.
  - Only rst_n=0 clears fault.
- pc_write with pc_next=64'hFFFF_FFFF_FFFF_FFFC:
  - pc_plus4=0.
  - rst_n low during REQ: imem_req=0 and pc=RESET_PC next cycle; a ready pulse one cycle later leaves the IR as NOP.
